// File: rtl/mem_access_stage.sv
// MEM stage: passes non-memory results to WB and runs loads and stores over a req/ack data-memory port.
// Optional macro MEM_TIMEOUT_EN adds an ack timeout that reports a bus error through misalign_o.
module mem_access_stage #(
  parameter logic [5:0]  OP_LW       = 6'b100011,
  parameter logic [5:0]  OP_LB       = 6'b100000,
  parameter logic [5:0]  OP_LBU      = 6'b100100,
  parameter logic [5:0]  OP_SW       = 6'b101011,
  parameter logic [5:0]  OP_SB       = 6'b101000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] regcData_i,
  input  logic [4:0]  regcAddr_i,
  input  logic        regcWrite_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] memData_i,
  output logic        stall_o,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        valid_o,
  output logic [31:0] regData_o,
  output logic [4:0]  regAddr_o,
  output logic        regWrite_o,
  output logic        misalign_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;

  logic [5:0] op_q;
  logic [1:0] lane_q;
  logic [4:0] dest_q;
  logic       dest_we_q;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        is_word;
  logic        aligned;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  always_comb begin
    is_load  = (op_i == OP_LW) || (op_i == OP_LB) || (op_i == OP_LBU);
    is_store = (op_i == OP_SW) || (op_i == OP_SB);
    is_mem   = is_load || is_store;
    is_word  = (op_i == OP_LW) || (op_i == OP_SW);
    aligned  = !is_word || (memAddr_i[1:0] == 2'b00);
    accept   = (state == IDLE) && valid_i && is_mem && aligned;
  end

  // EX holds its bundle while stalled; stall drops in the ack cycle so EX advances on that edge.
  assign stall_o = accept || ((state == BUSY) && !dm_ack && !timeout_hit);

  always_comb begin
    req_be    = 4'hF;
    req_wdata = '0;
    if (op_i == OP_SB) begin
      req_be    = 4'b0001 << memAddr_i[1:0];
      req_wdata = {4{memData_i[7:0]}};
    end else if (op_i == OP_SW) begin
      req_wdata = memData_i;
    end
  end

  always_comb begin
    lane_data = dm_rdata >> {lane_q, 3'b000};
    load_data = dm_rdata;
    if (op_q == OP_LB) begin
      load_data = {{24{lane_data[7]}}, lane_data[7:0]};
    end else if (op_q == OP_LBU) begin
      load_data = {24'h000000, lane_data[7:0]};
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CW-1:0] tmo_cnt;

  // Held at zero in IDLE, so every entry to BUSY starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign timeout_hit = (state == BUSY) && !dm_ack && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      dm_be      <= '0;
      valid_o    <= 1'b0;
      regData_o  <= '0;
      regAddr_o  <= '0;
      regWrite_o <= 1'b0;
      misalign_o <= 1'b0;
      op_q       <= '0;
      lane_q     <= '0;
      dest_q     <= '0;
      dest_we_q  <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o    <= 1'b1;
              regData_o  <= regcData_i;
              regAddr_o  <= regcAddr_i;
              regWrite_o <= regcWrite_i;
            end else if (!aligned) begin
              valid_o    <= 1'b1;
              misalign_o <= 1'b1;
              regAddr_o  <= regcAddr_i;
              regWrite_o <= 1'b0;
            end else begin
              state     <= BUSY;
              dm_req    <= 1'b1;
              dm_we     <= is_store;
              dm_addr   <= {memAddr_i[31:2], 2'b00};
              dm_wdata  <= req_wdata;
              dm_be     <= req_be;
              op_q      <= op_i;
              lane_q    <= memAddr_i[1:0];
              dest_q    <= regcAddr_i;
              dest_we_q <= regcWrite_i;
            end
          end
        end
        BUSY: begin
          if (dm_ack) begin
            state     <= IDLE;
            dm_req    <= 1'b0;
            valid_o   <= 1'b1;
            regAddr_o <= dest_q;
            if (dm_we) begin
              regWrite_o <= 1'b0;
            end else begin
              regData_o  <= load_data;
              regWrite_o <= dest_we_q;
            end
          end else if (timeout_hit) begin
            state      <= IDLE;
            dm_req     <= 1'b0;
            valid_o    <= 1'b1;
            misalign_o <= 1'b1;
            regAddr_o  <= dest_q;
            regWrite_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected WB bundles are queued at issue and popped on valid_o.
module tb_mem_access_stage;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_OR  = 6'b100101;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [5:0]  op_i;
  logic [31:0] regcData_i;
  logic [4:0]  regcAddr_i;
  logic        regcWrite_i;
  logic [31:0] memAddr_i;
  logic [31:0] memData_i;
  logic        stall_o;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        valid_o;
  logic [31:0] regData_o;
  logic [4:0]  regAddr_o;
  logic        regWrite_o;
  logic        misalign_o;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        write;
    logic        misalign;
    logic        chk_data;
  } wb_t;

  wb_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
    .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWrite_i(regcWrite_i),
    .memAddr_i(memAddr_i), .memData_i(memData_i), .stall_o(stall_o),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .valid_o(valid_o),
    .regData_o(regData_o), .regAddr_o(regAddr_o), .regWrite_o(regWrite_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] data, input logic [4:0] dest,
                       input logic we, input logic [31:0] maddr, input logic [31:0] mdata);
    valid_i     = 1'b1;
    op_i        = op;
    regcData_i  = data;
    regcAddr_i  = dest;
    regcWrite_i = we;
    memAddr_i   = maddr;
    memData_i   = mdata;
  endtask

  task automatic expect_wb(input logic [31:0] data, input logic [4:0] addr, input logic write,
                           input logic mis, input logic chk_data);
    wb_t e;
    e.data = data; e.addr = addr; e.write = write; e.misalign = mis; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  task automatic wb_check(input string tag);
    wb_t e;
    chk({tag, " valid_o"}, 32'(valid_o), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " regWrite_o"}, 32'(regWrite_o), 32'(e.write));
      chk({tag, " misalign_o"}, 32'(misalign_o), 32'(e.misalign));
      if (e.chk_data) begin
        chk({tag, " regData_o"}, regData_o, e.data);
        chk({tag, " regAddr_o"}, 32'(regAddr_o), 32'(e.addr));
      end
    end
  endtask

  function automatic logic [31:0] load_model(input logic [5:0] op, input logic [1:0] b,
                                             input logic [31:0] rdata);
    logic [7:0] byt;
    byt = rdata[8*b +: 8];
    if (op == OP_LB)  return {{24{byt[7]}}, byt};
    if (op == OP_LBU) return {24'h0, byt};
    return rdata;
  endfunction

  // Entered right after an aligned memory op is driven; leaves with the WB result checked.
  task automatic mem_access(input string tag, input int unsigned ack_cycle, input logic [31:0] rdata,
                            input logic exp_we, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic chk_wdata);
    int unsigned req_cnt;
    @(negedge clk);
    chk({tag, " stall on issue"}, 32'(stall_o), 32'd1);
    tick();
    chk({tag, " dm_we"}, 32'(dm_we), 32'(exp_we));
    chk({tag, " dm_addr"}, dm_addr, exp_addr);
    chk({tag, " dm_be"}, 32'(dm_be), 32'(exp_be));
    if (chk_wdata) chk({tag, " dm_wdata"}, dm_wdata, exp_wdata);
    req_cnt = 0;
    for (int unsigned c = 1; c <= ack_cycle; c++) begin
      if (dm_req) req_cnt++;
      if (c == ack_cycle) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata;
      end
      @(negedge clk);
      chk({tag, " stall in busy"}, 32'(stall_o), (c == ack_cycle) ? 32'd0 : 32'd1);
      tick();
    end
    dm_ack  = 1'b0;
    valid_i = 1'b0;
    chk({tag, " dm_req cycles"}, req_cnt, ack_cycle);
    chk({tag, " dm_req dropped"}, 32'(dm_req), 32'd0);
    wb_check(tag);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; op_i = '0; regcData_i = '0; regcAddr_i = '0; regcWrite_i = 1'b0;
    memAddr_i = '0; memData_i = '0; dm_ack = 1'b0; dm_rdata = '0;
    repeat (3) tick();
    chk("rst dm_req", 32'(dm_req), 32'd0);
    chk("rst dm_we", 32'(dm_we), 32'd0);
    chk("rst dm_be", 32'(dm_be), 32'd0);
    chk("rst dm_addr", dm_addr, 32'd0);
    chk("rst dm_wdata", dm_wdata, 32'd0);
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst regWrite_o", 32'(regWrite_o), 32'd0);
    chk("rst regData_o", regData_o, 32'd0);
    chk("rst regAddr_o", 32'(regAddr_o), 32'd0);
    chk("rst misalign_o", 32'(misalign_o), 32'd0);
    chk("rst stall_o", 32'(stall_o), 32'd0);
    rst = 1'b0;
    tick();

    // Non-memory op passes through with one cycle of latency.
    drive(OP_OR, 32'h1234, 5'd5, 1'b1, 32'h0, 32'h0);
    expect_wb(32'h1234, 5'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("or stall", 32'(stall_o), 32'd0);
    tick();
    valid_i = 1'b0;
    wb_check("or");
    tick();
    chk("or valid pulse", 32'(valid_o), 32'd0);
    chk("idle hold regData", regData_o, 32'h1234);

    drive(OP_LW, 32'h0, 5'd7, 1'b1, 32'h40, 32'h0);
    expect_wb(32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b1);
    mem_access("lw", 3, 32'hDEADBEEF, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0);

    // Next bundle offered the cycle after ack must be accepted.
    drive(OP_OR, 32'h5555AAAA, 5'd2, 1'b1, 32'h0, 32'h0);
    expect_wb(32'h5555AAAA, 5'd2, 1'b1, 1'b0, 1'b1);
    tick();
    valid_i = 1'b0;
    wb_check("or after lw");

    drive(OP_LB, 32'h0, 5'd8, 1'b1, 32'h43, 32'h0);
    expect_wb(load_model(OP_LB, 2'd3, 32'h80112233), 5'd8, 1'b1, 1'b0, 1'b1);
    mem_access("lb", 1, 32'h80112233, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    chk("lb value", regData_o, 32'hFFFFFF80);

    drive(OP_LBU, 32'h0, 5'd9, 1'b1, 32'h43, 32'h0);
    expect_wb(load_model(OP_LBU, 2'd3, 32'h80112233), 5'd9, 1'b1, 1'b0, 1'b1);
    mem_access("lbu", 2, 32'h80112233, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    chk("lbu value", regData_o, 32'h00000080);

    drive(OP_LB, 32'h0, 5'd10, 1'b1, 32'h11, 32'h0);
    expect_wb(32'h00000022, 5'd10, 1'b1, 1'b0, 1'b1);
    mem_access("lb lane1", 1, 32'h80112233, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);

    drive(OP_SB, 32'h0, 5'd3, 1'b1, 32'h21, 32'h000000AB);
    expect_wb(32'h0, 5'd3, 1'b0, 1'b0, 1'b0);
    mem_access("sb", 2, 32'h0, 1'b1, 32'h20, 4'b0010, 32'hABABABAB, 1'b1);

    drive(OP_SW, 32'h0, 5'd4, 1'b1, 32'h44, 32'hCAFEF00D);
    expect_wb(32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
    mem_access("sw", 1, 32'h0, 1'b1, 32'h44, 4'hF, 32'hCAFEF00D, 1'b1);

    // Misaligned word store is dropped without a request.
    drive(OP_SW, 32'h0, 5'd6, 1'b0, 32'h42, 32'h12345678);
    expect_wb(32'h0, 5'd6, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("sw mis stall", 32'(stall_o), 32'd0);
    tick();
    valid_i = 1'b0;
    chk("sw mis dm_req", 32'(dm_req), 32'd0);
    wb_check("sw mis");
    tick();
    chk("sw mis pulse", 32'(misalign_o), 32'd0);

    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("idle ack valid_o", 32'(valid_o), 32'd0);
    chk("idle ack dm_req", 32'(dm_req), 32'd0);

    // Reset during an access aborts it and a late ack is ignored.
    drive(OP_LW, 32'h0, 5'd11, 1'b1, 32'h80, 32'h0);
    tick();
    chk("abort dm_req busy", 32'(dm_req), 32'd1);
    rst = 1'b1;
    valid_i = 1'b0;
    tick();
    chk("abort dm_req", 32'(dm_req), 32'd0);
    chk("abort valid_o", 32'(valid_o), 32'd0);
    rst = 1'b0;
    tick();
    dm_ack = 1'b1;
    dm_rdata = 32'h13579BDF;
    tick();
    dm_ack = 1'b0;
    chk("late ack valid_o", 32'(valid_o), 32'd0);
    chk("late ack dm_req", 32'(dm_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      int unsigned req_cnt;
      drive(OP_LW, 32'h0, 5'd12, 1'b1, 32'h100, 32'h0);
      expect_wb(32'h0, 5'd12, 1'b0, 1'b1, 1'b0);
      tick();
      req_cnt = 0;
      for (int unsigned c = 0; c < 300 && dm_req; c++) begin
        req_cnt++;
        tick();
      end
      valid_i = 1'b0;
      chk("timeout req cycles", req_cnt, 32'd255);
      wb_check("timeout");
    end
`endif

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
